fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
// - Instruction-fetch stage. Owns the PC, drives the instruction-cache address, captures the returned word into the F/D pipeline register.
// - Handles cache stalls, decode back-pressure, branch redirects and trap redirects.
// - Sits between the PC/redirect sources (execute, trap unit) and decode.
// PARAMETERS
// - RESET_PC    32'h0000_1000   PC loaded on reset.
// - EXC_VECTOR  32'h0000_2000   trap-handler entry PC.
// PORTS
// - clock           in   1   single clock, rising edge.
// - reset           in   1   asynchronous, active-high.
// - icache_addr     out  32  fetch address; always equals pc.
// - icache_data     in   32  instruction word for icache_addr; valid when icache_stall=0.
// - icache_stall    in   1   cache cannot return data this cycle.
// - stall_d         in   1   decode cannot accept a new F/D entry.
// - redirect_valid  in   1   branch/jump taken.
// - redirect_pc     in   32  branch/jump target.
// - exc_valid       in   1   trap taken; target is EXC_VECTOR.
// - fd_valid        out  1   F/D entry holds a real instruction.
// - fd_instr        out  32  fetched instruction.
// - fd_pc           out  32  PC of fd_instr.
// - fd_misaligned   out  1   fd_pc[1:0] != 0; fd_instr is NOP.
// BEHAVIOUR
// - Reset (async):
//   - pc=RESET_PC, state=S_BOOT, pend_pc=0.
//   - fd_valid=0, fd_instr=NOP (32'h0000_0013), fd_pc=0, fd_misaligned=0.
// - Target selection, priority exc_valid > redirect_valid > sequential:
//   - tgt = exc_valid ? EXC_VECTOR : redirect_pc.
//   - "flush" = exc_valid | redirect_valid.
// - S_BOOT: no capture; fd_valid=0; next state S_RUN. A flush in S_BOOT is handled as in S_RUN.
// - S_RUN, evaluated in this order:
//   1. flush & !icache_stall: pc<=tgt, fd_valid<=0. Flush overrides stall_d.
//   2. flush & icache_stall: pend_pc<=tgt, fd_valid<=0, pc held, go S_PEND.
//   3. stall_d: F/D held, pc held. icache_stall is ignored.
//   4. icache_stall: fd_valid<=0 (bubble), pc held.
//   5. Otherwise: fd_valid<=1, fd_instr<=icache_data, fd_pc<=pc, pc<=pc+4.
//   - Case 5 misaligned PC (pc[1:0]!=0): fd_misaligned<=1 and fd_instr<=NOP; still valid.
// - S_PEND (stalled access to the stale PC still in flight):
//   - fd_valid held 0.
//   - A new flush overwrites pend_pc, with the same priority rule.
//   - On icache_stall=0: discard icache_data, pc<=pend_pc, go S_RUN. Fetch of the target starts next cycle.
// - Latency:
//   - Sequential fetch has 1-cycle latency (addr in cycle N -> F/D valid in N+1).
//   - Redirect with no stall: target word in F/D 2 cycles after flush.
// - Arithmetic: pc+4 wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000). No overflow flag.
// - Back-pressure: while stall_d=1, F/D outputs are bit-stable.
// - Reset mid-operation: asserting reset in any state clears everything immediately. Pending redirects are lost.
// STRUCTURE
// - Package fetch_pkg:
//   - NOP_INSTR constant.
//   - fetch_state_t enum {S_BOOT, S_RUN, S_PEND}.
//   - fd_reg_t struct {valid, instr, pc, misaligned}, for reuse by decode.
// - Single module, no sub-modules. Next-PC mux, FSM and F/D register are small enough to stay flat.
// TESTING
// - Reset release, stalls low, icache_data=addr-derived pattern:
//   - cycle 1 fd_valid=0.
//   - then fd_pc=0x1000, 0x1004, 0x1008 on consecutive cycles.
// - icache_stall high 3 cycles at pc=0x1008:
//   - 3 bubbles (fd_valid=0).
//   - pc held at 0x1008; then fd_pc=0x1008.
// - stall_d high 2 cycles with fd_pc=0x1004:
//   - F/D stable at 0x1004; icache_addr stays 0x1008.
//   - resumes with fd_pc=0x1008.
// - redirect_valid=1, redirect_pc=0x4000, exc_valid=1 in the same cycle, icache_stall=0:
//   - fd_valid=0 next cycle.
//   - fd_pc=0x2000 two cycles after.
// - redirect_pc=0x5000 during icache_stall=1, stall held 2 more cycles:
//   - state S_PEND; fd_valid=0 throughout.
//   - icache_addr=0x5000 the cycle after stall drops; fd_pc=0x5000 the cycle after that.
// - Edge cases:
//   - redirect_pc=0x5002: fd_misaligned=1, fd_instr=0x00000013.
//   - redirect_pc=0xFFFF_FFFC: next fd_pc=0x0000_0000.
//   - reset asserted mid-S_PEND: pc=0x1000, fd_valid=0 immediately.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch stage and the F/D pipeline register.
package fetch_pkg;

    localparam int unsigned XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        S_BOOT = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } fetch_state_t;

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc;
        logic            misaligned;
    } fd_reg_t;

endpackage

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the I-cache and fills the F/D register,
// handling cache stalls, decode back-pressure, and branch/trap redirects.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = 32'h0000_1000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_2000
) (
    input  logic        clock,
    input  logic        reset,
    output logic [31:0] icache_addr,
    input  logic [31:0] icache_data,
    input  logic        icache_stall,
    input  logic        stall_d,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        exc_valid,
    output logic        fd_valid,
    output logic [31:0] fd_instr,
    output logic [31:0] fd_pc,
    output logic        fd_misaligned
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_pc_q, pend_pc_d;
    fd_reg_t         fd_q, fd_d;

    logic            flush;
    logic [XLEN-1:0] tgt;

    // Trap outranks branch; both squash whatever is being fetched.
    assign flush = exc_valid | redirect_valid;
    assign tgt   = exc_valid ? EXC_VECTOR : redirect_pc;

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pend_pc_d = pend_pc_q;
        fd_d      = fd_q;

        unique case (state_q)
            S_BOOT, S_RUN: begin
                if (flush && !icache_stall) begin
                    pc_d       = tgt;
                    fd_d.valid = 1'b0;
                    state_d    = S_RUN;
                end else if (flush) begin
                    // Stale access still outstanding: park the target until it returns.
                    pend_pc_d  = tgt;
                    fd_d.valid = 1'b0;
                    state_d    = S_PEND;
                end else if (state_q == S_BOOT) begin
                    fd_d.valid = 1'b0;
                    state_d    = S_RUN;
                end else if (stall_d) begin
                    fd_d = fd_q;
                end else if (icache_stall) begin
                    fd_d.valid = 1'b0;
                end else begin
                    fd_d.valid = 1'b1;
                    fd_d.pc    = pc_q;
                    if (pc_q[1:0] != 2'b00) begin
                        fd_d.misaligned = 1'b1;
                        fd_d.instr      = NOP_INSTR;
                    end else begin
                        fd_d.misaligned = 1'b0;
                        fd_d.instr      = icache_data;
                    end
                    pc_d = pc_q + XLEN'(4);
                end
            end
            S_PEND: begin
                fd_d.valid = 1'b0;
                if (flush) begin
                    pend_pc_d = tgt;
                end
                // Returning word belongs to the squashed PC and is dropped.
                if (!icache_stall) begin
                    pc_d    = flush ? tgt : pend_pc_q;
                    state_d = S_RUN;
                end
            end
            default: begin
                state_d = S_BOOT;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= S_BOOT;
            pc_q      <= RESET_PC;
            pend_pc_q <= '0;
            fd_q      <= '{valid: 1'b0, instr: NOP_INSTR, pc: '0, misaligned: 1'b0};
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pend_pc_q <= pend_pc_d;
            fd_q      <= fd_d;
        end
    end

    assign icache_addr   = pc_q;
    assign fd_valid      = fd_q.valid;
    assign fd_instr      = fd_q.instr;
    assign fd_pc         = fd_q.pc;
    assign fd_misaligned = fd_q.misaligned;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: boot, sequential fetch, stalls, redirects, traps, reset.
module tb_fetch_stage;
    import fetch_pkg::*;

    localparam logic [31:0] PAT = 32'hA5C3_0000;

    logic        clock;
    logic        reset;
    logic [31:0] icache_addr;
    logic [31:0] icache_data;
    logic        icache_stall;
    logic        stall_d;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        exc_valid;
    logic        fd_valid;
    logic [31:0] fd_instr;
    logic [31:0] fd_pc;
    logic        fd_misaligned;

    int n_cmp;
    int n_err;

    fetch_stage dut (
        .clock          (clock),
        .reset          (reset),
        .icache_addr    (icache_addr),
        .icache_data    (icache_data),
        .icache_stall   (icache_stall),
        .stall_d        (stall_d),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .exc_valid      (exc_valid),
        .fd_valid       (fd_valid),
        .fd_instr       (fd_instr),
        .fd_pc          (fd_pc),
        .fd_misaligned  (fd_misaligned)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cache model: the word at an address is the address XOR a fixed pattern.
    assign icache_data = icache_addr ^ PAT;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_fd(input string tag, input logic [31:0] pc);
        chk({tag, ".valid"}, 32'(fd_valid), 32'd1);
        chk({tag, ".pc"}, fd_pc, pc);
        chk({tag, ".instr"}, fd_instr, pc ^ PAT);
        chk({tag, ".mis"}, 32'(fd_misaligned), 32'd0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        reset = 1'b1;
        icache_stall = 1'b0;
        stall_d = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        exc_valid = 1'b0;

        #2;
        chk("rst.valid", 32'(fd_valid), 32'd0);
        chk("rst.instr", fd_instr, 32'h0000_0013);
        chk("rst.pc", fd_pc, 32'h0);
        chk("rst.mis", 32'(fd_misaligned), 32'd0);
        chk("rst.addr", icache_addr, 32'h0000_1000);

        step();
        step();
        @(negedge clock);
        reset = 1'b0;

        // Boot cycle produces no entry, then sequential fetch.
        step();
        chk("boot.valid", 32'(fd_valid), 32'd0);
        chk("boot.addr", icache_addr, 32'h0000_1000);
        step();
        chk_fd("seq0", 32'h0000_1000);
        chk("seq0.addr", icache_addr, 32'h0000_1004);
        step();
        chk_fd("seq1", 32'h0000_1004);
        chk("seq1.addr", icache_addr, 32'h0000_1008);

        // Decode back-pressure for two cycles.
        stall_d = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step();
            chk_fd("stalld", 32'h0000_1004);
            chk("stalld.addr", icache_addr, 32'h0000_1008);
        end
        stall_d = 1'b0;
        step();
        chk_fd("stalld.resume", 32'h0000_1008);
        chk("stalld.resume.addr", icache_addr, 32'h0000_100C);

        // Back up to 0x1008, then hold the cache off for three cycles.
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_1008;
        step();
        chk("rd1008.valid", 32'(fd_valid), 32'd0);
        chk("rd1008.addr", icache_addr, 32'h0000_1008);
        redirect_valid = 1'b0;
        icache_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("istall.valid", 32'(fd_valid), 32'd0);
            chk("istall.addr", icache_addr, 32'h0000_1008);
        end
        icache_stall = 1'b0;
        step();
        chk_fd("istall.resume", 32'h0000_1008);
        chk("istall.resume.addr", icache_addr, 32'h0000_100C);

        // Trap and branch together: trap vector wins.
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_4000;
        exc_valid = 1'b1;
        step();
        chk("exc.valid", 32'(fd_valid), 32'd0);
        chk("exc.addr", icache_addr, 32'h0000_2000);
        redirect_valid = 1'b0;
        exc_valid = 1'b0;
        step();
        chk_fd("exc.fd", 32'h0000_2000);

        // Redirect during a cache stall parks the target.
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_5000;
        icache_stall = 1'b1;
        step();
        chk("pend0.valid", 32'(fd_valid), 32'd0);
        chk("pend0.state", 32'(dut.state_q), 32'(S_PEND));
        chk("pend0.addr", icache_addr, 32'h0000_2004);
        redirect_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            chk("pend.valid", 32'(fd_valid), 32'd0);
            chk("pend.state", 32'(dut.state_q), 32'(S_PEND));
        end
        icache_stall = 1'b0;
        step();
        chk("pend.exit.valid", 32'(fd_valid), 32'd0);
        chk("pend.exit.addr", icache_addr, 32'h0000_5000);
        step();
        chk_fd("pend.fd", 32'h0000_5000);

        // Misaligned target yields a valid NOP entry.
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_5002;
        step();
        redirect_valid = 1'b0;
        step();
        chk("mis.valid", 32'(fd_valid), 32'd1);
        chk("mis.pc", fd_pc, 32'h0000_5002);
        chk("mis.flag", 32'(fd_misaligned), 32'd1);
        chk("mis.instr", fd_instr, 32'h0000_0013);

        // PC wraps past the top of the address space.
        redirect_valid = 1'b1;
        redirect_pc = 32'hFFFF_FFFC;
        step();
        chk("wrap.addr0", icache_addr, 32'hFFFF_FFFC);
        redirect_valid = 1'b0;
        step();
        chk_fd("wrap.top", 32'hFFFF_FFFC);
        chk("wrap.addr1", icache_addr, 32'h0000_0000);
        step();
        chk_fd("wrap.zero", 32'h0000_0000);

        // Async reset while a redirect is parked.
        redirect_valid = 1'b1;
        redirect_pc = 32'h0000_7000;
        icache_stall = 1'b1;
        step();
        chk("rstp.state", 32'(dut.state_q), 32'(S_PEND));
        redirect_valid = 1'b0;
        #2;
        reset = 1'b1;
        #1;
        chk("rstp.addr", icache_addr, 32'h0000_1000);
        chk("rstp.valid", 32'(fd_valid), 32'd0);
        chk("rstp.instr", fd_instr, 32'h0000_0013);
        chk("rstp.state", 32'(dut.state_q), 32'(S_BOOT));
        icache_stall = 1'b0;
        step();
        chk("rstp.hold.addr", icache_addr, 32'h0000_1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
